// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared types, ByteEn encodings and sizing helper for dmem_responder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_BYTE1   = 4'b0010;
   localparam logic [3:0] BE_BYTE2   = 4'b0100;
   localparam logic [3:0] BE_BYTE3   = 4'b1000;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // Counter only ever holds values up to LATENCY-1.
   function automatic int cnt_width(input int latency);
      if (latency <= 2) return 1;
      return $clog2(latency);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module  : dmem_responder_if
// Purpose : Core load/store port bundle with request/ready handshake.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
   logic        MemReq;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [3:0]  ByteEn;
   logic [31:0] ReadData;
   logic        MemReady;
   logic        MemErr;
   logic        Busy;

   modport master (
      output MemReq, MemWrite, DataAdr, WriteData, ByteEn,
      input  ReadData, MemReady, MemErr, Busy
   );

   modport slave (
      input  MemReq, MemWrite, DataAdr, WriteData, ByteEn,
      output ReadData, MemReady, MemErr, Busy
   );
endinterface

`default_nettype wire

// File: rtl/dmem_store_array.sv
// ============================================================================
// Module  : dmem_store_array
// Purpose : WORDS x 32 storage, four byte-lane write enables, async read port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_store_array #(
   parameter int WORDS = 64,
   parameter int AW    = $clog2(WORDS)
) (
   input  wire logic          clk,
   input  wire logic          i_we,
   input  wire logic [AW-1:0] i_idx,
   input  wire logic [31:0]   i_wdata,
   input  wire logic [3:0]    i_be,
   output      logic [31:0]   o_rdata
);

   for (genvar gl = 0; gl < 4; gl++) begin : g_lane
      logic [7:0] r_lane [WORDS];

      always_ff @(posedge clk) begin
         if (i_we && i_be[gl]) begin
            r_lane[i_idx] <= i_wdata[8*gl +: 8];
         end
      end

      assign o_rdata[8*gl +: 8] = r_lane[i_idx];
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Purpose : Data memory with request/ready handshake and fixed access latency.
//           Optional out-of-range detection enabled by DMEM_RANGE_CHECK_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int WORDS   = 64,
   parameter int LATENCY = 2
) (
   input  wire logic       clk,
   input  wire logic       reset,
   dmem_responder_if.slave bus
);

   localparam int            AW         = $clog2(WORDS);
   localparam int            CW         = cnt_width(LATENCY);
   localparam logic [CW-1:0] C_CNT_LOAD = CW'(LATENCY - 1);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_write;
   logic          r_oor;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic [3:0]    r_be;
   logic [31:0]   r_rdata;

   logic          w_accept;
   logic          w_oor;
   logic          w_we;
   logic [31:0]   w_array_rd;
   logic          w_unused;

   assign w_accept = (r_state == IDLE) && bus.MemReq;
   assign w_unused = ^{bus.DataAdr[31:AW+2], bus.DataAdr[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
   assign w_oor = |bus.DataAdr[31:AW+2];
`else
   assign w_oor = 1'b0;
`endif

   // Reset high in RESP aborts the access, so it must also block the write.
   assign w_we = (r_state == RESP) && r_write && !r_oor && !reset;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.MemReq) w_next = (LATENCY > 1) ? BUSY : RESP;
         BUSY:    if (r_cnt == CW'(1)) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_oor   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_cnt   <= C_CNT_LOAD;
            r_write <= bus.MemWrite;
            r_oor   <= w_oor;
            r_idx   <= bus.DataAdr[AW+1:2];
            r_wdata <= bus.WriteData;
            r_be    <= bus.ByteEn;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if ((r_state == RESP) && !r_write) begin
            r_rdata <= r_oor ? '0 : w_array_rd;
         end
      end
   end

   always_comb begin
      bus.MemReady = 1'b0;
      bus.MemErr   = 1'b0;
      bus.Busy     = (r_state != IDLE);
      bus.ReadData = r_rdata;
      if ((r_state == RESP) && !reset) begin
         bus.MemReady = 1'b1;
         bus.MemErr   = r_oor;
         if (!r_write) bus.ReadData = r_oor ? '0 : w_array_rd;
      end
   end

   dmem_store_array #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_store_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_idx   (r_idx),
      .i_wdata (r_wdata),
      .i_be    (r_be),
      .o_rdata (w_array_rd)
   );

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Purpose : Scoreboard bench for dmem_responder at LATENCY=2 and LATENCY=1;
//           expectations follow DMEM_RANGE_CHECK_EN when it is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int WORDS = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_responder_if if2();
   dmem_responder_if if1();

   dmem_responder #(.WORDS(WORDS), .LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
   dmem_responder #(.WORDS(WORDS), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } op_t;

   exp_t        sb2[$];
   exp_t        sb1[$];
   logic [31:0] mem2 [WORDS];
   logic [31:0] mem1 [WORDS];
   int          checks = 0;
   int          errors = 0;

   // Reference model: apply the access to the shadow memory and queue the expected response.
   task automatic model_push(input int dut, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
      exp_t        e;
      logic        oor;
      int          idx;
      logic [31:0] cur;
      oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      oor = (a[31:2] >= 30'(WORDS));
`endif
      idx = int'(a[31:2] % 30'(WORDS));
      cur = (dut == 2) ? mem2[idx] : mem1[idx];
      if (w && !oor) begin
         for (int l = 0; l < 4; l++) if (be[l]) cur[8*l +: 8] = wd[8*l +: 8];
         if (dut == 2) mem2[idx] = cur; else mem1[idx] = cur;
      end
      e.data = oor ? 32'h0 : cur;
      e.err  = oor;
      if (dut == 2) sb2.push_back(e); else sb1.push_back(e);
   endtask

   function automatic logic rdy(input int dut);
      return (dut == 2) ? if2.MemReady : if1.MemReady;
   endfunction

   // Drives one access, drops MemReq right after acceptance, scrambles the other
   // inputs, then waits (bounded) for MemReady and returns what was observed.
   task automatic access(input int dut, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rd, output logic err, output int lat, output bit to);
      @(negedge clk);
      if (dut == 2) begin
         if2.MemReq = 1'b1; if2.MemWrite = w; if2.DataAdr = a; if2.WriteData = wd; if2.ByteEn = be;
      end else begin
         if1.MemReq = 1'b1; if1.MemWrite = w; if1.DataAdr = a; if1.WriteData = wd; if1.ByteEn = be;
      end
      @(negedge clk);
      if (dut == 2) begin
         if2.MemReq = 1'b0; if2.MemWrite = ~w; if2.DataAdr = $urandom; if2.WriteData = $urandom; if2.ByteEn = 4'hF;
      end else begin
         if1.MemReq = 1'b0; if1.MemWrite = ~w; if1.DataAdr = $urandom; if1.WriteData = $urandom; if1.ByteEn = 4'hF;
      end
      lat = 1;
      to  = 1'b0;
      while (!rdy(dut)) begin
         if (lat >= 20) begin to = 1'b1; break; end
         @(negedge clk);
         lat++;
      end
      rd  = (dut == 2) ? if2.ReadData : if1.ReadData;
      err = (dut == 2) ? if2.MemErr   : if1.MemErr;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (if2.ReadData !== 32'h0) begin errors++; $display("FAIL rst_rdata2: got %h expected 0", if2.ReadData); end
      checks++; if (if2.MemReady !== 1'b0)  begin errors++; $display("FAIL rst_ready2: got %b expected 0", if2.MemReady); end
      checks++; if (if2.MemErr !== 1'b0)    begin errors++; $display("FAIL rst_err2: got %b expected 0", if2.MemErr); end
      checks++; if (if2.Busy !== 1'b0)      begin errors++; $display("FAIL rst_busy2: got %b expected 0", if2.Busy); end
      checks++; if (if1.ReadData !== 32'h0) begin errors++; $display("FAIL rst_rdata1: got %h expected 0", if1.ReadData); end
      checks++; if (if1.MemReady !== 1'b0)  begin errors++; $display("FAIL rst_ready1: got %b expected 0", if1.MemReady); end
      checks++; if (if1.Busy !== 1'b0)      begin errors++; $display("FAIL rst_busy1: got %b expected 0", if1.Busy); end
   endtask

   task automatic test_store_load();
      op_t ops[$];
      exp_t e; logic [31:0] rd; logic err; int lat; bit to;
      ops.push_back('{1'b1, 32'h10, 32'hDEADBEEF, BE_WORD});
      ops.push_back('{1'b0, 32'h10, 32'h0,        BE_WORD});
      ops.push_back('{1'b1, 32'h20, 32'h11223344, BE_WORD});
      ops.push_back('{1'b1, 32'h20, 32'h000000AA, BE_BYTE0});
      ops.push_back('{1'b0, 32'h20, 32'h0,        4'h0});
      ops.push_back('{1'b1, 32'h20, 32'h55660000, BE_HALF_HI});
      ops.push_back('{1'b0, 32'h20, 32'h0,        4'h0});
      ops.push_back('{1'b1, 32'h24, 32'hFFFFFFFF, BE_WORD});
      ops.push_back('{1'b1, 32'h24, 32'h00000000, 4'b0000});
      ops.push_back('{1'b0, 32'h24, 32'h0,        4'h0});
      ops.push_back('{1'b1, 32'h2A, 32'h01020304, BE_WORD});
      ops.push_back('{1'b1, 32'h28, 32'h0000BB00, BE_BYTE1});
      ops.push_back('{1'b0, 32'h29, 32'h0,        4'h0});
      ops.push_back('{1'b1, 32'h00, 32'hCAFEF00D, BE_WORD});
      ops.push_back('{1'b0, 32'h00, 32'h0,        4'h0});
      foreach (ops[i]) begin
         model_push(2, ops[i].w, ops[i].a, ops[i].d, ops[i].be);
         access(2, ops[i].w, ops[i].a, ops[i].d, ops[i].be, rd, err, lat, to);
         e = sb2.pop_front();
         checks++; if (to || lat != 2) begin errors++; $display("FAIL sl_latency op%0d: got %0d expected 2", i, lat); end
         checks++; if (err !== e.err) begin errors++; $display("FAIL sl_err op%0d: got %b expected %b", i, err, e.err); end
         if (!ops[i].w) begin
            checks++; if (rd !== e.data) begin errors++; $display("FAIL sl_rdata op%0d: got %h expected %h", i, rd, e.data); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      exp_t e; logic [31:0] rd; logic err; int lat; bit to; int j;
      addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
      for (int i = 0; i < 4; i++) begin
         model_push(1, 1'b1, addrs[i], 32'hA0B0C000 + 32'(i * 17), BE_WORD);
         access(1, 1'b1, addrs[i], 32'hA0B0C000 + 32'(i * 17), BE_WORD, rd, err, lat, to);
         e = sb1.pop_front();
         checks++; if (to || lat != 1) begin errors++; $display("FAIL b2b_st_latency %0d: got %0d expected 1", i, lat); end
      end
      for (int i = 0; i < 4; i++) model_push(1, 1'b0, addrs[i], 32'h0, 4'h0);
      @(negedge clk);
      if1.MemReq = 1'b1; if1.MemWrite = 1'b0; if1.DataAdr = addrs[0];
      j = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++; if (if1.Busy !== 1'((k % 2) == 0)) begin errors++; $display("FAIL b2b_busy cyc%0d: got %b expected %b", k, if1.Busy, (k % 2) == 0); end
         checks++; if (if1.MemReady !== 1'((k % 2) == 0)) begin errors++; $display("FAIL b2b_ready cyc%0d: got %b expected %b", k, if1.MemReady, (k % 2) == 0); end
         if (if1.MemReady && sb1.size() > 0) begin
            e = sb1.pop_front();
            checks++; if (if1.ReadData !== e.data) begin errors++; $display("FAIL b2b_rdata %0d: got %h expected %h", j, if1.ReadData, e.data); end
            j++;
            if (j < 4) if1.DataAdr = addrs[j]; else if1.MemReq = 1'b0;
         end
      end
      if1.MemReq = 1'b0;
      checks++; if (sb1.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", sb1.size()); end
   endtask

   task automatic test_drop_req();
      exp_t e; logic [31:0] rd; logic err; int lat; bit to;
      model_push(2, 1'b1, 32'h40, 32'hA5A5A5A5, BE_WORD);
      access(2, 1'b1, 32'h40, 32'hA5A5A5A5, BE_WORD, rd, err, lat, to);
      e = sb2.pop_front();
      checks++; if (to || lat != 2) begin errors++; $display("FAIL drop_latency: got %0d expected 2", lat); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (if2.MemReady !== 1'b0 || if2.Busy !== 1'b0) begin errors++; $display("FAIL drop_extra cyc%0d: got ready=%b busy=%b expected 0", k, if2.MemReady, if2.Busy); end
      end
      model_push(2, 1'b0, 32'h40, 32'h0, 4'h0);
      access(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, lat, to);
      e = sb2.pop_front();
      checks++; if (to || rd !== e.data) begin errors++; $display("FAIL drop_commit: got %h expected %h", rd, e.data); end
   endtask

   task automatic test_reset_abort();
      exp_t e; logic [31:0] rd; logic err; int lat; bit to;
      model_push(2, 1'b1, 32'h30, 32'h00000001, BE_WORD);
      access(2, 1'b1, 32'h30, 32'h00000001, BE_WORD, rd, err, lat, to);
      e = sb2.pop_front();
      for (int phase = 1; phase <= 2; phase++) begin
         @(negedge clk);
         if2.MemReq = 1'b1; if2.MemWrite = 1'b1; if2.DataAdr = 32'h30; if2.WriteData = 32'hFFFF0000; if2.ByteEn = BE_WORD;
         @(negedge clk);
         if2.MemReq = 1'b0;
         checks++; if (if2.Busy !== 1'b1) begin errors++; $display("FAIL abort_busy ph%0d: got %b expected 1", phase, if2.Busy); end
         if (phase == 2) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         checks++; if (if2.Busy !== 1'b0 || if2.MemReady !== 1'b0 || if2.MemErr !== 1'b0 || if2.ReadData !== 32'h0) begin
            errors++; $display("FAIL abort_outputs ph%0d: got busy=%b ready=%b err=%b rdata=%h expected all 0", phase, if2.Busy, if2.MemReady, if2.MemErr, if2.ReadData);
         end
         model_push(2, 1'b0, 32'h30, 32'h0, 4'h0);
         access(2, 1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat, to);
         e = sb2.pop_front();
         checks++; if (to || rd !== e.data) begin errors++; $display("FAIL abort_nowrite ph%0d: got %h expected %h", phase, rd, e.data); end
      end
   endtask

   task automatic test_range();
      op_t ops[$];
      exp_t e; logic [31:0] rd; logic err; int lat; bit to;
      ops.push_back('{1'b0, 32'h100, 32'h0,        4'h0});
      ops.push_back('{1'b1, 32'h100, 32'h12345678, BE_WORD});
      ops.push_back('{1'b0, 32'h000, 32'h0,        4'h0});
      ops.push_back('{1'b0, 32'h110, 32'h0,        4'h0});
      foreach (ops[i]) begin
         model_push(2, ops[i].w, ops[i].a, ops[i].d, ops[i].be);
         access(2, ops[i].w, ops[i].a, ops[i].d, ops[i].be, rd, err, lat, to);
         e = sb2.pop_front();
         checks++; if (to || lat != 2) begin errors++; $display("FAIL rng_latency op%0d: got %0d expected 2", i, lat); end
         checks++; if (err !== e.err) begin errors++; $display("FAIL rng_err op%0d: got %b expected %b", i, err, e.err); end
         if (!ops[i].w) begin
            checks++; if (rd !== e.data) begin errors++; $display("FAIL rng_rdata op%0d: got %h expected %h", i, rd, e.data); end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      if2.MemReq = 1'b0; if2.MemWrite = 1'b0; if2.DataAdr = '0; if2.WriteData = '0; if2.ByteEn = '0;
      if1.MemReq = 1'b0; if1.MemWrite = 1'b0; if1.DataAdr = '0; if1.WriteData = '0; if1.ByteEn = '0;
      test_reset();
      test_store_load();
      test_back_to_back();
      test_drop_req();
      test_reset_abort();
      test_range();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
